// File: rtl/csr_excp_ctrl.sv
// Exception / ERTN sequencer: owns CRMD, PRMD, ESTAT, ERA, BADV, EENTRY,
// stalls and flushes on a writeback report, then redirects the IFU.
module csr_excp_ctrl #(
  parameter logic [31:0] EENTRY_RST = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc,
  input  logic        wb_excp,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        wb_badv_valid,
  input  logic [31:0] wb_badv,
  input  logic        wb_ertn,
  output logic        excp_flush,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic [1:0]  crmd_plv,
  output logic        crmd_ie
);

  localparam logic [13:0] ADDR_CRMD   = 14'h0;
  localparam logic [13:0] ADDR_PRMD   = 14'h1;
  localparam logic [13:0] ADDR_ESTAT  = 14'h5;
  localparam logic [13:0] ADDR_ERA    = 14'h6;
  localparam logic [13:0] ADDR_BADV   = 14'h7;
  localparam logic [13:0] ADDR_EENTRY = 14'hC;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;

  state_t state, next_state;

  // CSR fields
  logic        crmd_da;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esub;
  logic [31:0] era, badv;
  logic [25:0] eentry_va;

  // Next CSR values
  logic [1:0]  plv_n, pplv_n;
  logic        ie_n, da_n, pie_n;
  logic [5:0]  ecode_n;
  logic [8:0]  esub_n;
  logic [31:0] era_n, badv_n;
  logic [25:0] eentry_n;

  // Latched report
  logic        lat_exc, lat_badv_valid;
  logic [31:0] lat_pc, lat_badv;
  logic [5:0]  lat_ecode;
  logic [8:0]  lat_esub;

  logic        hw_exc, hw_ertn, accept;
  logic        wb_ready_d, excp_flush_d, redirect_valid_d;
  logic [31:0] redirect_pc_d;

  assign accept  = (state == IDLE) && wb_valid && (wb_excp || wb_ertn);
  assign hw_exc  = (state == FLUSH) && lat_exc;
  assign hw_ertn = (state == FLUSH) && !lat_exc;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = FLUSH;
      FLUSH:   next_state = REDIR;
      REDIR:   if (redirect_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output next values; redirect target captured on FLUSH -> REDIR from post-update CSRs
  always_comb begin
    wb_ready_d       = (next_state == IDLE);
    excp_flush_d     = (next_state == FLUSH);
    redirect_valid_d = (next_state == REDIR);
    redirect_pc_d    = redirect_pc;
    if (state == FLUSH) redirect_pc_d = lat_exc ? {eentry_n, 6'b0} : era_n;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_ready       <= 1'b1;
      excp_flush     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      wb_ready       <= wb_ready_d;
      excp_flush     <= excp_flush_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
    end
  end

  // Capture the accepted report; both flags high counts as an exception
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_exc        <= 1'b0;
      lat_pc         <= 32'h0;
      lat_ecode      <= 6'h0;
      lat_esub       <= 9'h0;
      lat_badv_valid <= 1'b0;
      lat_badv       <= 32'h0;
    end else if (accept) begin
      lat_exc        <= wb_excp;
      lat_pc         <= wb_pc;
      lat_ecode      <= wb_ecode;
      lat_esub       <= wb_esubcode;
      lat_badv_valid <= wb_badv_valid;
      lat_badv       <= wb_badv;
    end
  end

  // CSR next values: software write first, hardware update overrides per field
  always_comb begin
    plv_n    = crmd_plv;
    ie_n     = crmd_ie;
    da_n     = crmd_da;
    pplv_n   = prmd_pplv;
    pie_n    = prmd_pie;
    ecode_n  = estat_ecode;
    esub_n   = estat_esub;
    era_n    = era;
    badv_n   = badv;
    eentry_n = eentry_va;
    if (csr_we) begin
      case (csr_waddr)
        ADDR_CRMD:   begin plv_n = csr_wdata[1:0]; ie_n = csr_wdata[2]; da_n = csr_wdata[3]; end
        ADDR_PRMD:   begin pplv_n = csr_wdata[1:0]; pie_n = csr_wdata[2]; end
        ADDR_ESTAT:  begin ecode_n = csr_wdata[21:16]; esub_n = csr_wdata[30:22]; end
        ADDR_ERA:    era_n = csr_wdata;
        ADDR_BADV:   badv_n = csr_wdata;
        ADDR_EENTRY: eentry_n = csr_wdata[31:6];
        default:     ;
      endcase
    end
    if (hw_exc) begin
      pplv_n  = crmd_plv;
      pie_n   = crmd_ie;
      plv_n   = 2'b0;
      ie_n    = 1'b0;
      era_n   = lat_pc;
      ecode_n = lat_ecode;
      esub_n  = lat_esub;
      if (lat_badv_valid) badv_n = lat_badv;
    end
    if (hw_ertn) begin
      plv_n = prmd_pplv;
      ie_n  = prmd_pie;
    end
  end

  // CSR registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_plv    <= 2'b0;
      crmd_ie     <= 1'b0;
      crmd_da     <= 1'b1;
      prmd_pplv   <= 2'b0;
      prmd_pie    <= 1'b0;
      estat_ecode <= 6'h0;
      estat_esub  <= 9'h0;
      era         <= 32'h0;
      badv        <= 32'h0;
      eentry_va   <= EENTRY_RST[31:6];
    end else begin
      crmd_plv    <= plv_n;
      crmd_ie     <= ie_n;
      crmd_da     <= da_n;
      prmd_pplv   <= pplv_n;
      prmd_pie    <= pie_n;
      estat_ecode <= ecode_n;
      estat_esub  <= esub_n;
      era         <= era_n;
      badv        <= badv_n;
      eentry_va   <= eentry_n;
    end
  end

  // CSR read mux
  always_comb begin
    case (csr_raddr)
      ADDR_CRMD:   csr_rdata = {28'b0, crmd_da, crmd_ie, crmd_plv};
      ADDR_PRMD:   csr_rdata = {29'b0, prmd_pie, prmd_pplv};
      ADDR_ESTAT:  csr_rdata = {1'b0, estat_esub, estat_ecode, 16'b0};
      ADDR_ERA:    csr_rdata = era;
      ADDR_BADV:   csr_rdata = badv;
      ADDR_EENTRY: csr_rdata = {eentry_va, 6'b0};
      default:     csr_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_csr_excp_ctrl.sv
// Directed bench for csr_excp_ctrl with hand-computed expectations.
module tb_csr_excp_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid, wb_ready, wb_excp, wb_badv_valid, wb_ertn;
  logic [31:0] wb_pc, wb_badv;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        excp_flush, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic        csr_we;
  logic [13:0] csr_waddr, csr_raddr;
  logic [31:0] csr_wdata, csr_rdata;
  logic [1:0]  crmd_plv;
  logic        crmd_ie;

  int checks = 0;
  int errors = 0;

  csr_excp_ctrl #(.EENTRY_RST(32'h1c000000)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
    .wb_excp(wb_excp), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_badv_valid(wb_badv_valid), .wb_badv(wb_badv), .wb_ertn(wb_ertn),
    .excp_flush(excp_flush), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .crmd_plv(crmd_plv), .crmd_ie(crmd_ie)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs and checks happen 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [13:0] addr, input logic [31:0] exp);
    csr_raddr = addr;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic report(input logic excp, input logic ertn, input logic [31:0] pc,
                        input logic [5:0] ec, input logic [8:0] esc,
                        input logic bv, input logic [31:0] ba);
    wb_valid = 1'b1; wb_excp = excp; wb_ertn = ertn; wb_pc = pc;
    wb_ecode = ec; wb_esubcode = esc; wb_badv_valid = bv; wb_badv = ba;
  endtask

  task automatic idle_wb();
    wb_valid = 1'b0; wb_excp = 1'b0; wb_ertn = 1'b0;
  endtask

  task automatic swr(input logic [13:0] addr, input logic [31:0] data);
    csr_we = 1'b1; csr_waddr = addr; csr_wdata = data;
  endtask

  initial begin
    resetn = 1'b0;
    idle_wb();
    wb_pc = '0; wb_ecode = '0; wb_esubcode = '0; wb_badv_valid = 1'b0; wb_badv = '0;
    redirect_ready = 1'b1;
    csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0; csr_raddr = '0;
    repeat (3) step();
    resetn = 1'b1;
    step();

    // Reset state
    rd("rst_crmd", 14'h0, 32'h8);
    rd("rst_eentry", 14'hC, 32'h1c000000);
    rd("rst_badv", 14'h7, 32'h0);
    chk("rst_wb_ready", 32'(wb_ready), 32'h1);
    chk("rst_rvalid", 32'(redirect_valid), 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_flush", 32'(excp_flush), 32'h0);

    // Unmapped reads, write masking, read-during-write returns old value
    rd("unmapped", 14'h2, 32'h0);
    swr(14'h5, 32'hffffffff);
    rd("estat_rdw_old", 14'h5, 32'h0);
    step();
    swr(14'hC, 32'h1c00003f);
    rd("estat_mask", 14'h5, 32'h7fff0000);
    step();
    csr_we = 1'b0;
    rd("eentry_mask", 14'hC, 32'h1c000000);

    // Plain retiring instruction is ignored
    report(1'b0, 1'b0, 32'h1c000010, 6'h0, 9'h0, 1'b0, 32'h0);
    step();
    idle_wb();
    chk("noflag_flush", 32'(excp_flush), 32'h0);
    chk("noflag_ready", 32'(wb_ready), 32'h1);

    // Exception with faulting address
    report(1'b1, 1'b0, 32'h1c000020, 6'h08, 9'h0, 1'b1, 32'h1c000101);
    step();
    idle_wb();
    chk("e1_flush", 32'(excp_flush), 32'h1);
    chk("e1_ready_lo", 32'(wb_ready), 32'h0);
    chk("e1_rvalid_lo", 32'(redirect_valid), 32'h0);
    step();
    chk("e1_flush_1cyc", 32'(excp_flush), 32'h0);
    chk("e1_rvalid", 32'(redirect_valid), 32'h1);
    chk("e1_rpc", redirect_pc, 32'h1c000000);
    rd("e1_era", 14'h6, 32'h1c000020);
    rd("e1_badv", 14'h7, 32'h1c000101);
    rd("e1_estat", 14'h5, 32'h00080000);
    rd("e1_crmd", 14'h0, 32'h8);
    step();
    chk("e1_back_idle", 32'(wb_ready), 32'h1);
    chk("e1_rvalid_off", 32'(redirect_valid), 32'h0);

    // PLV3/IE1 with DA kept set, so CRMD goes 0xF -> 0x8 -> 0xF
    swr(14'h0, 32'hf);
    step();
    csr_we = 1'b0;
    rd("e2_crmd_sw", 14'h0, 32'hf);
    chk("e2_plv_port", 32'(crmd_plv), 32'h3);
    chk("e2_ie_port", 32'(crmd_ie), 32'h1);
    report(1'b1, 1'b0, 32'h1c000040, 6'h0b, 9'h001, 1'b0, 32'hdeadbeef);
    step();
    idle_wb();
    step();
    rd("e2_prmd", 14'h1, 32'h7);
    rd("e2_crmd", 14'h0, 32'h8);
    rd("e2_badv_keep", 14'h7, 32'h1c000101);
    rd("e2_estat", 14'h5, 32'h004b0000);
    rd("e2_era", 14'h6, 32'h1c000040);
    step();

    // ERTN back to ERA
    report(1'b0, 1'b1, 32'h1c000080, 6'h0, 9'h0, 1'b0, 32'h0);
    step();
    idle_wb();
    chk("r1_flush", 32'(excp_flush), 32'h1);
    step();
    chk("r1_rvalid", 32'(redirect_valid), 32'h1);
    chk("r1_rpc", redirect_pc, 32'h1c000040);
    rd("r1_crmd", 14'h0, 32'hf);
    rd("r1_era_keep", 14'h6, 32'h1c000040);
    step();

    // IFU stall: redirect held, new reports not consumed, EENTRY write ignored by target
    redirect_ready = 1'b0;
    report(1'b1, 1'b0, 32'h1c000100, 6'h01, 9'h0, 1'b0, 32'h0);
    step();
    idle_wb();
    step();
    swr(14'hC, 32'h1c000400);
    report(1'b0, 1'b1, 32'h1c000180, 6'h0, 9'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st_rvalid%0d", i), 32'(redirect_valid), 32'h1);
      chk($sformatf("st_rpc%0d", i), redirect_pc, 32'h1c000000);
      chk($sformatf("st_ready%0d", i), 32'(wb_ready), 32'h0);
      step();
      csr_we = 1'b0;
      if (i == 3) idle_wb();
    end
    rd("st_eentry", 14'hC, 32'h1c000400);
    redirect_ready = 1'b1;
    step();
    chk("st_idle", 32'(wb_ready), 32'h1);
    step();
    chk("st_no_consume", 32'(excp_flush), 32'h0);

    // Both flags: exception path; ERA write during FLUSH loses to hardware
    redirect_ready = 1'b0;
    report(1'b1, 1'b1, 32'h1c000200, 6'h02, 9'h0, 1'b0, 32'h0);
    step();
    idle_wb();
    chk("b_flush", 32'(excp_flush), 32'h1);
    swr(14'h6, 32'h12345678);
    step();
    csr_we = 1'b0;
    chk("b_rvalid", 32'(redirect_valid), 32'h1);
    chk("b_rpc", redirect_pc, 32'h1c000400);
    rd("b_era", 14'h6, 32'h1c000200);
    rd("b_crmd", 14'h0, 32'h8);
    rd("b_prmd", 14'h1, 32'h0);

    // Reset during REDIR
    resetn = 1'b0;
    #1;
    chk("rr_rvalid", 32'(redirect_valid), 32'h0);
    chk("rr_ready", 32'(wb_ready), 32'h1);
    rd("rr_badv", 14'h7, 32'h0);
    rd("rr_eentry", 14'hC, 32'h1c000000);
    rd("rr_era", 14'h6, 32'h0);
    redirect_ready = 1'b1;
    step();
    resetn = 1'b1;
    step();
    chk("rr_rvalid_after", 32'(redirect_valid), 32'h0);
    chk("rr_flush_after", 32'(excp_flush), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
